// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults, arbitration mode encoding and small helpers for the
// port-B memory arbiter.
package mem_port_arbiter_pkg;

  localparam int NREQ_DEF   = 3;
  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Requester index following idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake plus memory port-B signals of the arbiter.
// The slave modport is the arbiter; master is the requesters and the memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  logic               prio_mode;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_data;
  logic               mem_wren;
  logic [DW-1:0]      mem_q;
  logic               busy;

  modport master (
    output prio_mode, req, we, addr, wdata, mem_q,
    input  gnt, rvalid, rdata, mem_addr, mem_data, mem_wren, busy
  );

  modport slave (
    input  prio_mode, req, we, addr, wdata, mem_q,
    output gnt, rvalid, rdata, mem_addr, mem_data, mem_wren, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate eligible by ptr, keep the lowest
// set bit, rotate back. ptr = 0 gives plain fixed priority.
module mem_port_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic          any_o
);

  logic [N-1:0] rot_s;
  logic [N-1:0] first_s;

  assign rot_s   = N'({eligible_i, eligible_i} >> ptr_i);
  assign first_s = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
  assign win_o   = N'(({first_s, first_s} << ptr_i) >> N);
  assign any_o   = |eligible_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory port B among NREQ requesters: one registered access per cycle,
// read data steered back through an RD_LAT-deep one-hot return pipeline.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d, pick_ptr_s, sel_ptr_s;
  logic [AW-1:0]   mem_addr_q, mem_addr_d, sel_addr_s;
  logic [DW-1:0]   mem_data_q, mem_data_d, sel_data_s;
  logic            mem_wren_q, mem_wren_d, sel_we_s;
  logic [NREQ-1:0] eligible_s, win_s, issue_s;
  logic            any_s, fixed_s, busy_s;
  logic [NREQ-1:0] pipe_q [RD_LAT];

  // A requester granted last cycle may still show req; it must not win again.
  assign eligible_s = bus.req & ~gnt_q;
  assign fixed_s    = (arb_mode_e'(bus.prio_mode) == ARB_FIXED);
  assign pick_ptr_s = fixed_s ? {PW{1'b0}} : ptr_q;

  mem_port_arbiter_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .eligible_i (eligible_s),
    .ptr_i      (pick_ptr_s),
    .win_o      (win_s),
    .any_o      (any_s)
  );

  // Winner's request fields selected by one-hot AND-OR; idle cycles hold address/data.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    sel_we_s   = 1'b0;
    sel_ptr_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = sel_addr_s | ({AW{win_s[i]}} & bus.addr[i*AW +: AW]);
      sel_data_s = sel_data_s | ({DW{win_s[i]}} & bus.wdata[i*DW +: DW]);
      sel_we_s   = sel_we_s | (win_s[i] & bus.we[i]);
      sel_ptr_s  = sel_ptr_s | ({PW{win_s[i]}} & PW'(wrap_inc(i, NREQ)));
    end
    gnt_d      = win_s;
    mem_addr_d = any_s ? sel_addr_s : mem_addr_q;
    mem_data_d = any_s ? sel_data_s : mem_data_q;
    mem_wren_d = any_s & sel_we_s;
    ptr_d      = (any_s && !fixed_s) ? sel_ptr_s : ptr_q;
  end

  // Reads enter the return pipeline in the cycle their grant is visible.
  assign issue_s = mem_wren_q ? {NREQ{1'b0}} : gnt_q;

  // Grant, memory-port and pointer registers plus the read-return pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q      <= '0;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      pipe_q[0]  <= issue_s;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  // Any occupied return stage means a read is still in flight.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      busy_s = busy_s | (|pipe_q[k]);
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rvalid   = pipe_q[RD_LAT-1];
  assign bus.rdata    = bus.mem_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wren = mem_wren_q;
  assign bus.busy     = busy_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first port-B memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NREQ   = 3;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  int            total_cnt = 0;
  int            bad_cnt   = 0;
  logic [DW-1:0] mem [256];
  logic [2:0]    rr_exp [6]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0]    fix_exp [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Port-B memory: one-cycle read, write-first, preloaded while reset is low.
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h10] <= 16'hBEEF;
    end else if (bus.mem_wren) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_data;
    end
    bus.mem_q <= bus.mem_wren ? bus.mem_data : mem[bus.mem_addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]             = 1'b1;
    bus.we[i]              = w;
    bus.addr[i*AW +: AW]   = a;
    bus.wdata[i*DW +: DW]  = d;
  endtask

  initial begin
    bus.prio_mode = 1'b0;
    bus.req       = 3'b111;
    bus.we        = '0;
    bus.addr      = '0;
    bus.wdata     = '0;

    // Reset held with all requesters asking.
    @(negedge clk);
    check_eq("rst_gnt",    32'(bus.gnt),      32'h0);
    check_eq("rst_rvalid", 32'(bus.rvalid),   32'h0);
    check_eq("rst_wren",   32'(bus.mem_wren), 32'h0);
    check_eq("rst_addr",   32'(bus.mem_addr), 32'h0);
    check_eq("rst_busy",   32'(bus.busy),     32'h0);
    bus.req = '0;
    #5 reset = 1'b1;

    // Round-robin with every requester continuously asking.
    @(negedge clk);
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("rr_gnt", 32'(bus.gnt), 32'(rr_exp[k]));
      if (k > 0) check_eq("rr_rvalid", 32'(bus.rvalid), 32'(rr_exp[k-1]));
    end
    bus.req = '0;
    @(negedge clk);
    check_eq("rr_tail_rvalid", 32'(bus.rvalid), 32'h4);
    check_eq("idle_gnt",       32'(bus.gnt),    32'h0);
    @(negedge clk);

    // Single read by requester 1.
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_eq("rd_gnt",  32'(bus.gnt),      32'h2);
    check_eq("rd_addr", 32'(bus.mem_addr), 32'h0010);
    check_eq("rd_wren", 32'(bus.mem_wren), 32'h0);
    bus.req = '0;
    @(negedge clk);
    check_eq("rd_rvalid", 32'(bus.rvalid), 32'h2);
    check_eq("rd_rdata",  32'(bus.rdata),  32'hBEEF);
    check_eq("rd_busy",   32'(bus.busy),   32'h1);
    check_eq("rd_gnt_pulse", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    check_eq("rd_rvalid_off", 32'(bus.rvalid),   32'h0);
    check_eq("rd_busy_off",   32'(bus.busy),     32'h0);
    check_eq("idle_addr_hold", 32'(bus.mem_addr), 32'h0010);

    // Fixed priority with requesters 0 and 2 held; ptr is 2 here.
    bus.prio_mode = 1'b1;
    set_req(0, 1'b0, 16'h0000, 16'h0000);
    set_req(2, 1'b0, 16'h0010, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("fix_gnt", 32'(bus.gnt), 32'(fix_exp[k]));
    end
    bus.req       = '0;
    bus.prio_mode = 1'b0;
    @(negedge clk);
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    set_req(2, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_eq("ptr_kept_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);

    // Write then read of the same address.
    set_req(0, 1'b1, 16'h0020, 16'h1234);
    @(negedge clk);
    check_eq("wr_gnt",  32'(bus.gnt),      32'h1);
    check_eq("wr_wren", 32'(bus.mem_wren), 32'h1);
    check_eq("wr_addr", 32'(bus.mem_addr), 32'h0020);
    check_eq("wr_data", 32'(bus.mem_data), 32'h1234);
    bus.req = '0;
    bus.we  = '0;
    set_req(2, 1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    check_eq("wr_rd_gnt",    32'(bus.gnt),      32'h4);
    check_eq("wr_rd_wren",   32'(bus.mem_wren), 32'h0);
    check_eq("wr_no_rvalid", 32'(bus.rvalid),   32'h0);
    bus.req = '0;
    @(negedge clk);
    check_eq("wr_rd_rvalid", 32'(bus.rvalid), 32'h4);
    check_eq("wr_rd_rdata",  32'(bus.rdata),  32'h1234);

    // Reset while a read is in flight.
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_eq("rst6_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    reset   = 1'b0;
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    set_req(2, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_eq("rst6_rvalid", 32'(bus.rvalid), 32'h0);
    check_eq("rst6_busy",   32'(bus.busy),   32'h0);
    check_eq("rst6_gnt0",   32'(bus.gnt),    32'h0);
    #2 reset = 1'b1;
    @(negedge clk);
    check_eq("rst6_first_gnt", 32'(bus.gnt),    32'h2);
    check_eq("rst6_rvalid2",   32'(bus.rvalid), 32'h0);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
